// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: producer offers/readies plus the registered CDB broadcast.
// master = producers/ROB side, slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int RSNUM_W = 3
);
    logic               alu_valid;
    logic [TAG_W-1:0]   alu_tag;
    logic [DATA_W-1:0]  alu_data;
    logic [RSNUM_W-1:0] alu_rsnum;
    logic               alu_ready;

    logic               ls_valid;
    logic [TAG_W-1:0]   ls_tag;
    logic [DATA_W-1:0]  ls_data;
    logic               ls_ready;

    logic               cdb_valid;
    logic               cdb_src;
    logic [TAG_W-1:0]   cdb_tag;
    logic [DATA_W-1:0]  cdb_data;
    logic [RSNUM_W-1:0] cdb_rsnum;

    modport master (
        output alu_valid, alu_tag, alu_data, alu_rsnum,
        output ls_valid, ls_tag, ls_data,
        input  alu_ready, ls_ready,
        input  cdb_valid, cdb_src, cdb_tag, cdb_data, cdb_rsnum
    );

    modport slave (
        input  alu_valid, alu_tag, alu_data, alu_rsnum,
        input  ls_valid, ls_tag, ls_data,
        output alu_ready, ls_ready,
        output cdb_valid, cdb_src, cdb_tag, cdb_data, cdb_rsnum
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result queues (ALU, LS) granting one head per cycle; CDB_RR_EN selects round-robin, else ALU-first.
// Latency: push at edge N into an empty queue, uncontested, is broadcast after edge N+1 for one cycle (no bypass).
// Backpressure: *_ready = queue not full && !flush, taken before the same-cycle pop; flush drops everything queued.
module cdb_arbiter #(
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int RSNUM_W = 3,
    parameter int QDEPTH  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    cdb_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_depth
        $error("cdb_arbiter: QDEPTH must be a power of two and at least 2");
    end

    // Both queues share one entry layout; LS entries carry rsnum 0 so the
    // broadcast path needs no per-source zeroing.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  dat;
        logic [RSNUM_W-1:0] rsnum;
    } ent_t;

    ent_t       w_in   [2];
    ent_t       w_head [2];
    ent_t       w_sel_head;
    logic [1:0] w_vld;
    logic [1:0] w_rdy;
    logic [1:0] w_wr;
    logic [1:0] w_rd;
    logic [1:0] w_ne;
    logic       w_grant;
    logic       w_grant_ls;

    assign w_in[0] = '{tag: bus.alu_tag, dat: bus.alu_data, rsnum: bus.alu_rsnum};
    assign w_in[1] = '{tag: bus.ls_tag,  dat: bus.ls_data,  rsnum: '0};
    assign w_vld   = {bus.ls_valid, bus.alu_valid};

    for (genvar s = 0; s < 2; s++) begin : g_q
        ent_t             r_mem [QDEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_cnt;

        assign w_rdy[s]  = rst && !flush && (r_cnt < CNT_W'(QDEPTH));
        // A free-tag offer is handshaken but never stored.
        assign w_wr[s]   = w_vld[s] && w_rdy[s] && (w_in[s].tag != '0);
        assign w_ne[s]   = (r_cnt != '0);
        assign w_head[s] = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_wr[s]) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_rd[s]) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_cnt <= r_cnt + CNT_W'(w_wr[s]) - CNT_W'(w_rd[s]);
            end
        end

        always_ff @(posedge clk) begin
            if (w_wr[s]) begin
                r_mem[r_wr_ptr] <= w_in[s];
            end
        end
    end

`ifdef CDB_RR_EN
    logic r_last_grant;

    // On a contest, serve the source that did not win last time.
    assign w_grant_ls = w_ne[1] && (!w_ne[0] || !r_last_grant);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (flush) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_grant_ls;
        end
    end
`else
    assign w_grant_ls = w_ne[1] && !w_ne[0];
`endif

    assign w_grant    = !flush && (w_ne[0] || w_ne[1]);
    assign w_rd[0]    = w_grant && !w_grant_ls;
    assign w_rd[1]    = w_grant && w_grant_ls;
    assign w_sel_head = w_head[w_grant_ls];

    logic               r_cdb_vld;
    logic               r_cdb_src;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_dat;
    logic [RSNUM_W-1:0] r_cdb_rsnum;

    always_ff @(posedge clk) begin
        if (!rst || !w_grant) begin
            r_cdb_vld   <= 1'b0;
            r_cdb_src   <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_dat   <= '0;
            r_cdb_rsnum <= '0;
        end else begin
            r_cdb_vld   <= 1'b1;
            r_cdb_src   <= w_grant_ls;
            r_cdb_tag   <= w_sel_head.tag;
            r_cdb_dat   <= w_sel_head.dat;
            r_cdb_rsnum <= w_sel_head.rsnum;
        end
    end

    assign bus.alu_ready = w_rdy[0];
    assign bus.ls_ready  = w_rdy[1];
    assign bus.cdb_valid = r_cdb_vld;
    assign bus.cdb_src   = r_cdb_src;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_dat;
    assign bus.cdb_rsnum = r_cdb_rsnum;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default parameters); expectations follow CDB_RR_EN when defined.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] t, input logic [31:0] d, input logic [2:0] r);
        bus.alu_valid = v;
        bus.alu_tag   = t;
        bus.alu_data  = d;
        bus.alu_rsnum = r;
    endtask

    task automatic drive_ls(input logic v, input logic [4:0] t, input logic [31:0] d);
        bus.ls_valid = v;
        bus.ls_tag   = t;
        bus.ls_data  = d;
    endtask

    task automatic count_bcast(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.cdb_valid) cnt++;
            tick();
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_vld"},   bus.cdb_valid, 0);
        check({pfx, "_src"},   bus.cdb_src,   0);
        check({pfx, "_tag"},   bus.cdb_tag,   0);
        check({pfx, "_data"},  bus.cdb_data,  0);
        check({pfx, "_rsnum"}, bus.cdb_rsnum, 0);
    endtask

    logic [4:0] exp_ct [4];
    logic       exp_cs [4];
    logic [4:0] got_tag [$];
    logic       got_src [$];
    logic [4:0] q_alu [$];
    logic [4:0] q_ls  [$];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic [4:0] a_tag;
        logic [4:0] l_tag;
        logic [4:0] e;
        logic       a_ok;
        logic       l_ok;
        logic       drv;
        logic       v_rdy;
        logic       seen;
        int         a_acc_n;
        int         l_acc_n;
        int         v_acc_n;
        int         exp_acc;

`ifdef CDB_RR_EN
        exp_ct  = '{5'd1, 5'd2, 5'd4, 5'd6};
        exp_cs  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_acc = 3;
`else
        exp_ct  = '{5'd1, 5'd4, 5'd2, 5'd6};
        exp_cs  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_acc = 2;
`endif

        // Reset
        rst   = 1'b0;
        flush = 1'b0;
        drive_alu(0, 0, 0, 0);
        drive_ls(0, 0, 0);
        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_alu_rdy", bus.alu_ready, 0);
        check("rst_ls_rdy",  bus.ls_ready,  0);
        rst = 1'b1;
        #1;
        check("rel_alu_rdy", bus.alu_ready, 1);
        check("rel_ls_rdy",  bus.ls_ready,  1);

        // Single ALU result
        drive_alu(1, 5'd3, 32'h0000_0010, 3'd5);
        tick();
        drive_alu(0, 0, 0, 0);
        check("single_nobypass", bus.cdb_valid, 0);
        tick();
        check("single_vld",   bus.cdb_valid, 1);
        check("single_src",   bus.cdb_src,   0);
        check("single_tag",   bus.cdb_tag,   3);
        check("single_data",  bus.cdb_data,  32'h10);
        check("single_rsnum", bus.cdb_rsnum, 5);
        tick();
        check_idle_outputs("single_after");

        // Free tag
        drive_alu(1, 5'd0, 32'hFFFF_FFFF, 3'd2);
        check("free_rdy_pre", bus.alu_ready, 1);
        tick();
        drive_alu(0, 0, 0, 0);
        check("free_rdy_post", bus.alu_ready, 1);
        count_bcast(4, cnt);
        check("free_no_bcast", cnt, 0);

        // Flush mid-operation
        for (int i = 0; i < 2; i++) begin
            drive_alu(1, 5'(15 + i), 32'hD000_0000 + i, 3'(i));
            drive_ls(1, 5'(25 + i), 32'hE000_0000 + i);
            tick();
        end
        drive_ls(0, 0, 0);
        drive_alu(1, 5'd7, 32'h0000_0777, 3'd1);
        flush = 1'b1;
        #1;
        check("flush_alu_rdy_low", bus.alu_ready, 0);
        check("flush_ls_rdy_low",  bus.ls_ready,  0);
        tick();
        flush = 1'b0;
        drive_alu(0, 0, 0, 0);
        #1;
        check("flush_vld",     bus.cdb_valid, 0);
        check("flush_alu_rdy", bus.alu_ready, 1);
        check("flush_ls_rdy",  bus.ls_ready,  1);
        count_bcast(5, cnt);
        check("flush_no_bcast", cnt, 0);

        // Contest
        drive_alu(1, 5'd1, 32'hC000_0001, 3'd1);
        drive_ls(1, 5'd2, 32'hC000_0002);
        tick();
        drive_alu(1, 5'd4, 32'hC000_0004, 3'd4);
        drive_ls(1, 5'd6, 32'hC000_0006);
        tick();
        drive_alu(0, 0, 0, 0);
        drive_ls(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (bus.cdb_valid) begin
                got_tag.push_back(bus.cdb_tag);
                got_src.push_back(bus.cdb_src);
            end
            tick();
        end
        check("contest_count", got_tag.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_tag.size()) begin
                check($sformatf("contest_tag%0d", k), got_tag[k], exp_ct[k]);
                check($sformatf("contest_src%0d", k), got_src[k], exp_cs[k]);
            end
        end

        // Full-queue backpressure with both sources saturated
        flush = 1'b1;
        tick();
        flush = 1'b0;
        a_tag   = 5'd11;
        l_tag   = 5'd21;
        a_acc_n = 0;
        l_acc_n = 0;
        seen    = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            drv = (cyc < 8);
            drive_alu(drv, a_tag, 32'hA000_0000 | 32'(a_tag), a_tag[2:0]);
            drive_ls(drv, l_tag, 32'hB000_0000 | 32'(l_tag));
            #1;
            a_ok = bus.alu_valid && bus.alu_ready;
            l_ok = bus.ls_valid && bus.ls_ready;
`ifdef CDB_RR_EN
            v_rdy   = bus.alu_ready;
            v_acc_n = a_acc_n;
`else
            v_rdy   = bus.ls_ready;
            v_acc_n = l_acc_n;
`endif
            if (drv && !v_rdy && !seen) begin
                seen = 1'b1;
                check("bp_accepts_before_full", v_acc_n, exp_acc);
            end
            if (a_ok) q_alu.push_back(a_tag);
            if (l_ok) q_ls.push_back(l_tag);
            tick();
            if (a_ok) begin a_tag++; a_acc_n++; end
            if (l_ok) begin l_tag++; l_acc_n++; end
            if (bus.cdb_valid) begin
                if (bus.cdb_src == 1'b0) begin
                    e = (q_alu.size() != 0) ? q_alu.pop_front() : 5'd0;
                    check("bp_alu_tag",   bus.cdb_tag,   e);
                    check("bp_alu_data",  bus.cdb_data,  32'hA000_0000 | 32'(e));
                    check("bp_alu_rsnum", bus.cdb_rsnum, e[2:0]);
                end else begin
                    e = (q_ls.size() != 0) ? q_ls.pop_front() : 5'd0;
                    check("bp_ls_tag",   bus.cdb_tag,   e);
                    check("bp_ls_data",  bus.cdb_data,  32'hB000_0000 | 32'(e));
                    check("bp_ls_rsnum", bus.cdb_rsnum, 0);
                end
            end
        end
        check("bp_full_seen", seen, 1);
        check("bp_alu_left", q_alu.size(), 0);
        check("bp_ls_left",  q_ls.size(),  0);

        // Reset mid-broadcast
        drive_alu(1, 5'd9, 32'h0000_0009, 3'd3);
        drive_ls(1, 5'd10, 32'h0000_000A);
        tick();
        drive_alu(0, 0, 0, 0);
        drive_ls(0, 0, 0);
        tick();
        check("rmb_vld_pre", bus.cdb_valid, 1);
        rst = 1'b0;
        tick();
        check_idle_outputs("rmb");
        check("rmb_alu_rdy", bus.alu_ready, 0);
        check("rmb_ls_rdy",  bus.ls_ready,  0);
        rst = 1'b1;
        #1;
        check("rmb_rel_alu_rdy", bus.alu_ready, 1);
        check("rmb_rel_ls_rdy",  bus.ls_ready,  1);
        count_bcast(4, cnt);
        check("rmb_queues_empty", cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
